// File: rtl/axis_fanout.sv
// One-register AXI-Stream broadcaster: each accepted beat is held until every
// channel selected by its destination mask has taken it.
module axis_fanout #(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 16,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (KEEP_ENABLE) ? ((DATA_WIDTH + 7) / 8) : 1,
    parameter bit LAST_ENABLE = 1'b1,
    parameter bit USER_ENABLE = 1'b0,
    parameter int USER_WIDTH  = (USER_ENABLE) ? 8 : 1
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic [USER_WIDTH-1:0]          s_axis_tuser,
    input  logic [CHANNELS-1:0]            s_axis_tmask,

    output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CHANNELS*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [CHANNELS-1:0]            m_axis_tvalid,
    input  logic [CHANNELS-1:0]            m_axis_tready,
    output logic [CHANNELS-1:0]            m_axis_tlast,
    output logic [CHANNELS*USER_WIDTH-1:0] m_axis_tuser
);

    logic [CHANNELS-1:0]   pending_q, pending_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                  last_q, last_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    logic [CHANNELS-1:0]   stall;
    logic                  s_ready;
    logic                  accept;

    always_comb begin
        // Channels still owed the held beat after this cycle's handshakes.
        stall     = pending_q & ~m_axis_tready;
        s_ready   = rst & (stall == '0);
        accept    = s_axis_tvalid & s_ready;

        pending_d = stall;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        user_d    = user_q;

        if (accept) begin
            // A new beat overrides this cycle's clears; a zero mask drops the beat.
            pending_d = s_axis_tmask;
            data_d    = s_axis_tdata;
            keep_d    = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
            last_d    = LAST_ENABLE ? s_axis_tlast : 1'b0;
            user_d    = USER_ENABLE ? s_axis_tuser : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            user_q    <= '0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            user_q    <= user_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = pending_q;
    assign m_axis_tdata  = {CHANNELS{data_q}};
    assign m_axis_tkeep  = {CHANNELS{keep_q}};
    assign m_axis_tlast  = {CHANNELS{last_q}};
    assign m_axis_tuser  = {CHANNELS{user_q}};

endmodule

// File: tb/tb_axis_fanout.sv
// Directed and randomized checks of axis_fanout against per-channel delivery queues.
module tb_axis_fanout;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int KW = 2;
    localparam int UW = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    s_tdata = '0;
    logic [KW-1:0]    s_tkeep = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             s_tlast = 1'b0;
    logic [UW-1:0]    s_tuser = '0;
    logic [CH-1:0]    s_tmask = '0;
    logic [CH*DW-1:0] m_tdata;
    logic [CH*KW-1:0] m_tkeep;
    logic [CH-1:0]    m_tvalid;
    logic [CH-1:0]    m_tready = '0;
    logic [CH-1:0]    m_tlast;
    logic [CH*UW-1:0] m_tuser;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t exp_q [CH][$];

    axis_fanout dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .s_axis_tmask(s_tmask),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CH-1:0] m);
        s_tvalid = v;
        s_tdata  = d;
        s_tmask  = m;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", s_tready); end
        vectors++;
        if (m_tvalid !== 4'b0000) begin miscompares++; $display("FAIL reset_valid got %b exp 0000", m_tvalid); end
        vectors++;
        if (m_tdata !== '0) begin miscompares++; $display("FAIL reset_data got %h exp 0", m_tdata); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (s_tready !== 1'b1) begin miscompares++; $display("FAIL idle_ready got %b exp 1", s_tready); end
        vectors++;
        if (m_tvalid !== 4'b0000) begin miscompares++; $display("FAIL idle_valid got %b exp 0000", m_tvalid); end
        cyc();
    endtask

    task automatic test_single_beat();
        m_tready = 4'b1111;
        s_tkeep = 2'b11;
        drive(1'b1, 16'hA5A5, 4'b1111);
        #1;
        vectors++;
        if (s_tready !== 1'b1) begin miscompares++; $display("FAIL single_ready0 got %b exp 1", s_tready); end
        cyc();
        drive(1'b1, 16'hA5A6, 4'b1111);
        #1;
        vectors++;
        if (m_tvalid !== 4'b1111) begin miscompares++; $display("FAIL single_valid got %b exp 1111", m_tvalid); end
        vectors++;
        if (m_tdata !== {CH{16'hA5A5}}) begin miscompares++; $display("FAIL single_data got %h exp a5a5 x4", m_tdata); end
        vectors++;
        if (s_tready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b exp 1", s_tready); end
        cyc();
        drive(1'b0, '0, '0);
        #1;
        vectors++;
        if (m_tvalid !== 4'b1111 || m_tdata !== {CH{16'hA5A6}}) begin
            miscompares++; $display("FAIL b2b_second got %b/%h exp 1111/a5a6", m_tvalid, m_tdata);
        end
        cyc();
        #1;
        vectors++;
        if (m_tvalid !== 4'b0000) begin miscompares++; $display("FAIL single_oneshot got %b exp 0000", m_tvalid); end
        cyc();
    endtask

    task automatic test_staggered();
        m_tready = 4'b0000;
        drive(1'b1, 16'h5555, 4'b1111);
        cyc();
        drive(1'b1, 16'h1234, 4'b1111);
        m_tready = 4'b0001;
        #1;
        vectors++;
        if (m_tvalid !== 4'b1111 || s_tready !== 1'b0) begin
            miscompares++; $display("FAIL stag_a got %b/%b exp 1111/0", m_tvalid, s_tready);
        end
        cyc();
        m_tready = 4'b0100;
        #1;
        vectors++;
        if (m_tvalid !== 4'b1110 || s_tready !== 1'b0) begin
            miscompares++; $display("FAIL stag_b got %b/%b exp 1110/0", m_tvalid, s_tready);
        end
        cyc();
        m_tready = 4'b1010;
        #1;
        vectors++;
        if (m_tvalid !== 4'b1010 || s_tready !== 1'b1 || m_tdata !== {CH{16'h5555}}) begin
            miscompares++; $display("FAIL stag_c got %b/%b/%h exp 1010/1/5555", m_tvalid, s_tready, m_tdata);
        end
        cyc();
        drive(1'b0, '0, '0);
        m_tready = 4'b1111;
        #1;
        vectors++;
        if (m_tvalid !== 4'b1111 || m_tdata !== {CH{16'h1234}}) begin
            miscompares++; $display("FAIL stag_next got %b/%h exp 1111/1234", m_tvalid, m_tdata);
        end
        cyc();
        #1;
        vectors++;
        if (m_tvalid !== 4'b0000) begin miscompares++; $display("FAIL stag_empty got %b exp 0000", m_tvalid); end
        cyc();
    endtask

    task automatic test_mask_select();
        m_tready = 4'b1111;
        drive(1'b1, 16'd1, 4'b0010);
        cyc();
        drive(1'b1, 16'd2, 4'b1000);
        #1;
        vectors++;
        if (m_tvalid !== 4'b0010 || m_tdata[1*DW +: DW] !== 16'd1) begin
            miscompares++; $display("FAIL mask_b1 got %b/%h exp 0010/0001", m_tvalid, m_tdata[1*DW +: DW]);
        end
        cyc();
        drive(1'b1, 16'd3, 4'b0000);
        #1;
        vectors++;
        if (m_tvalid !== 4'b1000 || m_tdata[3*DW +: DW] !== 16'd2) begin
            miscompares++; $display("FAIL mask_b2 got %b/%h exp 1000/0002", m_tvalid, m_tdata[3*DW +: DW]);
        end
        cyc();
        drive(1'b1, 16'd4, 4'b0010);
        #1;
        vectors++;
        if (m_tvalid !== 4'b0000 || s_tready !== 1'b1) begin
            miscompares++; $display("FAIL mask_b3 got %b/%b exp 0000/1", m_tvalid, s_tready);
        end
        cyc();
        drive(1'b0, '0, '0);
        #1;
        vectors++;
        if (m_tvalid !== 4'b0010 || m_tdata[1*DW +: DW] !== 16'd4) begin
            miscompares++; $display("FAIL mask_b4 got %b/%h exp 0010/0004", m_tvalid, m_tdata[1*DW +: DW]);
        end
        cyc();
    endtask

    task automatic test_last_keep();
        m_tready = 4'b0000;
        s_tkeep = 2'b01;
        s_tlast = 1'b1;
        drive(1'b1, 16'h00C3, 4'b0101);
        cyc();
        drive(1'b0, '0, '0);
        s_tlast = 1'b0;
        s_tkeep = 2'b11;
        #1;
        vectors++;
        if (m_tvalid !== 4'b0101) begin miscompares++; $display("FAIL lk_valid got %b exp 0101", m_tvalid); end
        vectors++;
        if (m_tkeep[0 +: KW] !== 2'b01 || m_tkeep[2*KW +: KW] !== 2'b01) begin
            miscompares++; $display("FAIL lk_keep got %b exp ch0/ch2 01", m_tkeep);
        end
        vectors++;
        if (m_tlast[0] !== 1'b1 || m_tlast[2] !== 1'b1) begin
            miscompares++; $display("FAIL lk_last got %b exp ch0/ch2 1", m_tlast);
        end
        m_tready = 4'b1111;
        cyc();
    endtask

    task automatic test_reset_mid();
        m_tready = 4'b0000;
        drive(1'b1, 16'hBEEF, 4'b0110);
        cyc();
        drive(1'b0, '0, '0);
        #1;
        vectors++;
        if (m_tvalid !== 4'b0110) begin miscompares++; $display("FAIL rm_pending got %b exp 0110", m_tvalid); end
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (m_tvalid !== 4'b0000 || s_tready !== 1'b0) begin
            miscompares++; $display("FAIL rm_async got %b/%b exp 0000/0", m_tvalid, s_tready);
        end
        @(negedge clk);
        rst = 1'b1;
        m_tready = 4'b1111;
        drive(1'b1, 16'h7777, 4'b0001);
        #1;
        vectors++;
        if (s_tready !== 1'b1 || m_tvalid !== 4'b0000) begin
            miscompares++; $display("FAIL rm_release got %b/%b exp 1/0000", s_tready, m_tvalid);
        end
        cyc();
        drive(1'b0, '0, '0);
        #1;
        vectors++;
        if (m_tvalid !== 4'b0001 || m_tdata[0 +: DW] !== 16'h7777) begin
            miscompares++; $display("FAIL rm_newbeat got %b/%h exp 0001/7777", m_tvalid, m_tdata[0 +: DW]);
        end
        cyc();
        #1;
        vectors++;
        if (m_tvalid !== 4'b0000) begin miscompares++; $display("FAIL rm_old_gone got %b exp 0000", m_tvalid); end
        cyc();
    endtask

    task automatic test_random();
        beat_t nb;
        logic exp_rdy;
        logic [CH-1:0] hs;
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        for (int n = 0; n < 600; n++) begin
            if (n >= 580) begin
                s_tvalid = 1'b0;
                m_tready = 4'b1111;
            end else begin
                s_tvalid = ($urandom_range(0, 9) < 7);
                m_tready = 4'($urandom_range(0, 15));
            end
            s_tdata = 16'($urandom);
            s_tkeep = 2'($urandom_range(0, 3));
            s_tlast = 1'($urandom_range(0, 1));
            s_tmask = 4'($urandom_range(0, 15));
            #1;
            exp_rdy = 1'b1;
            for (int c = 0; c < CH; c++) begin
                if (exp_q[c].size() != 0 && !m_tready[c]) exp_rdy = 1'b0;
                hs[c] = (exp_q[c].size() != 0) && m_tready[c];
                vectors++;
                if (m_tvalid[c] !== (exp_q[c].size() != 0)) begin
                    miscompares++;
                    $display("FAIL rnd_valid cyc %0d ch %0d got %b exp %b", n, c, m_tvalid[c], exp_q[c].size() != 0);
                end else if (exp_q[c].size() != 0) begin
                    vectors++;
                    if (m_tdata[c*DW +: DW] !== exp_q[c][0].d || m_tkeep[c*KW +: KW] !== exp_q[c][0].k ||
                        m_tlast[c] !== exp_q[c][0].l) begin
                        miscompares++;
                        $display("FAIL rnd_beat cyc %0d ch %0d got %h/%b/%b exp %h/%b/%b", n, c,
                                 m_tdata[c*DW +: DW], m_tkeep[c*KW +: KW], m_tlast[c],
                                 exp_q[c][0].d, exp_q[c][0].k, exp_q[c][0].l);
                    end
                end
            end
            vectors++;
            if (s_tready !== exp_rdy) begin
                miscompares++; $display("FAIL rnd_ready cyc %0d got %b exp %b", n, s_tready, exp_rdy);
            end
            for (int c = 0; c < CH; c++) if (hs[c]) void'(exp_q[c].pop_front());
            if (s_tvalid && exp_rdy) begin
                nb.d = s_tdata;
                nb.k = s_tkeep;
                nb.l = s_tlast;
                for (int c = 0; c < CH; c++) if (s_tmask[c]) exp_q[c].push_back(nb);
            end
            cyc();
        end
        s_tvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_staggered();
        test_mask_select();
        test_last_keep();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
